// File: rtl/xcorr_peak_search.sv
// Peak-lag search over streamed cross-correlation frames for six microphone pairs.
// A completed frame updates all six lags at once and fires a fixed-length ena pulse.
module xcorr_peak_search #(
  parameter int MAX_LAG = 6,
  parameter int CORR_W  = 32,
  parameter int ENA_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     corr_valid,
  input  logic signed [CORR_W-1:0] corr_val,
  output logic signed [32:0]       lag_diff1,
  output logic signed [32:0]       lag_diff2,
  output logic signed [32:0]       lag_diff3,
  output logic signed [32:0]       lag_diff4,
  output logic signed [32:0]       lag_diff5,
  output logic signed [32:0]       lag_diff6,
  output logic                     ena,
  output logic                     busy,
  output logic                     frame_err
);

  localparam int LW = $clog2(MAX_LAG) + 2;
  localparam int EW = $clog2(ENA_W + 1);
  localparam logic signed [LW-1:0] LAG_HI    = LW'(MAX_LAG);
  localparam logic signed [LW-1:0] LAG_LO    = -LAG_HI;
  localparam logic [2:0]           PAIR_LAST = 3'd5;
  localparam logic [EW-1:0]        ENA_LOAD  = EW'(ENA_W - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                    r_state;
  logic [2:0]                r_pair_cnt;
  logic signed [LW-1:0]      r_lag_cnt;
  logic signed [CORR_W-1:0]  r_max;
  logic signed [LW-1:0]      r_best;
  logic signed [LW-1:0]      r_shadow [6];
  logic signed [32:0]        r_lag_out [6];
  logic                      r_ena;
  logic                      r_ena_pend;
  logic [EW-1:0]             r_ena_cnt;
  logic                      r_busy;
  logic                      r_frame_err;

  logic                      w_restart;
  logic                      w_accept;
  logic [2:0]                w_pair;
  logic signed [LW-1:0]      w_lag;
  logic                      w_take;
  logic signed [LW-1:0]      w_best;
  logic                      w_lag_end;
  logic                      w_complete;

  function automatic logic signed [32:0] sext33(input logic signed [LW-1:0] v);
    return {{(33 - LW){v[LW-1]}}, v};
  endfunction

  // A restarting sample is always pair 0, lag -MAX_LAG, whatever the counters say.
  always_comb begin
    w_restart = frame_start && ((r_state == S_IDLE) || (r_state == S_SCAN));
    w_accept  = corr_valid && (w_restart || (r_state == S_SCAN));
    if (w_restart) begin
      w_pair = 3'd0;
      w_lag  = LAG_LO;
    end else begin
      w_pair = r_pair_cnt;
      w_lag  = r_lag_cnt;
    end
    w_take     = (w_lag == LAG_LO) || (corr_val > r_max);
    w_best     = w_take ? w_lag : r_best;
    w_lag_end  = (w_lag == LAG_HI);
    w_complete = w_accept && w_lag_end && (w_pair == PAIR_LAST);
  end

  // Scan FSM, running max, shadow lags, published lags and ena pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pair_cnt  <= 3'd0;
      r_lag_cnt   <= LAG_LO;
      r_max       <= '0;
      r_best      <= '0;
      r_ena       <= 1'b0;
      r_ena_pend  <= 1'b0;
      r_ena_cnt   <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        r_shadow[k]  <= '0;
        r_lag_out[k] <= '0;
      end
    end else begin
      r_frame_err <= frame_start && (r_state == S_SCAN);

      if (w_accept) begin
        r_max  <= w_take ? corr_val : r_max;
        r_best <= w_best;
        if (w_lag_end) begin
          r_shadow[w_pair] <= w_best;
          r_lag_cnt        <= LAG_LO;
          r_pair_cnt       <= w_pair + 3'd1;
        end else begin
          r_lag_cnt  <= w_lag + LW'(1);
          r_pair_cnt <= w_pair;
        end
      end else if (w_restart || (r_state != S_SCAN)) begin
        r_lag_cnt  <= LAG_LO;
        r_pair_cnt <= 3'd0;
      end

      // The last pair's result is still in flight, so it bypasses its shadow.
      if (w_complete) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        for (int k = 0; k < 5; k++) begin
          r_lag_out[k] <= sext33(r_shadow[k]);
        end
        r_lag_out[5] <= sext33(w_best);
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= w_restart ? S_SCAN : S_IDLE;
            r_busy  <= w_restart;
          end
          S_SCAN: begin
            r_state <= S_SCAN;
            r_busy  <= 1'b1;
          end
          S_DONE: begin
            r_state <= frame_start ? S_SCAN : S_IDLE;
            r_busy  <= frame_start;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end

      // A completion during a live pulse inserts one low cycle before the new pulse.
      if (w_complete) begin
        if (r_ena) begin
          r_ena      <= 1'b0;
          r_ena_pend <= 1'b1;
        end else begin
          r_ena     <= 1'b1;
          r_ena_cnt <= ENA_LOAD;
        end
      end else if (r_ena_pend) begin
        r_ena      <= 1'b1;
        r_ena_pend <= 1'b0;
        r_ena_cnt  <= ENA_LOAD;
      end else if (r_ena) begin
        if (r_ena_cnt == EW'(0)) begin
          r_ena <= 1'b0;
        end else begin
          r_ena_cnt <= r_ena_cnt - EW'(1);
        end
      end
    end
  end

  assign lag_diff1 = r_lag_out[0];
  assign lag_diff2 = r_lag_out[1];
  assign lag_diff3 = r_lag_out[2];
  assign lag_diff4 = r_lag_out[3];
  assign lag_diff5 = r_lag_out[4];
  assign lag_diff6 = r_lag_out[5];
  assign ena       = r_ena;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_xcorr_peak_search.sv
// Directed, table-driven bench for xcorr_peak_search (MAX_LAG=6/ENA_W=4 main instance,
// plus a MAX_LAG=1/ENA_W=24 instance for the back-to-back ena truncation case).
module tb_xcorr_peak_search;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start;
  logic corr_valid;
  logic signed [31:0] corr_val;
  logic signed [32:0] l1, l2, l3, l4, l5, l6;
  logic signed [32:0] m1, m2, m3, m4, m5, m6;
  logic ena, busy, ferr, ena2, busy2, ferr2;
  logic signed [32:0] ld [6];
  logic signed [32:0] ld2 [6];

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int mode;
    bit gaps;
    int pk [6];
    int ex [6];
  } vec_t;
  vec_t vecs [4];

  logic signed [32:0] pre_ld [6];
  logic pre_busy, pre_ena2, err_seen;
  int prev [6];

  always #5 clk = ~clk;

  xcorr_peak_search #(.MAX_LAG(6), .CORR_W(32), .ENA_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .corr_valid(corr_valid),
    .corr_val(corr_val), .lag_diff1(l1), .lag_diff2(l2), .lag_diff3(l3),
    .lag_diff4(l4), .lag_diff5(l5), .lag_diff6(l6), .ena(ena), .busy(busy),
    .frame_err(ferr));

  xcorr_peak_search #(.MAX_LAG(1), .CORR_W(32), .ENA_W(24)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .corr_valid(corr_valid),
    .corr_val(corr_val), .lag_diff1(m1), .lag_diff2(m2), .lag_diff3(m3),
    .lag_diff4(m4), .lag_diff5(m5), .lag_diff6(m6), .ena(ena2), .busy(busy2),
    .frame_err(ferr2));

  assign ld[0] = l1;  assign ld[1] = l2;  assign ld[2] = l3;
  assign ld[3] = l4;  assign ld[4] = l5;  assign ld[5] = l6;
  assign ld2[0] = m1; assign ld2[1] = m2; assign ld2[2] = m3;
  assign ld2[3] = m4; assign ld2[4] = m5; assign ld2[5] = m6;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int val(input int m, input int mode, input int p, input int l, input int pk);
    int d;
    d = (l > pk) ? (l - pk) : (pk - l);
    case (mode)
      0: return 1000 - 10 * d;
      1: begin
        if (d != 0 && l == -m) return int'(32'h8000_0000);
        return -1000 - 10 * d;
      end
      default: return (p == 0 && (l == -2 || l == 4)) ? -100 : -500;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fs: 0 = separate frame_start pulse, 1 = frame_start with first sample, 2 = no start.
  // Returns one cycle after the edge that accepted the last sample.
  task automatic send_frame(input int m, input int mode, input int pk [6], input bit gaps, input int fs);
    if (fs == 0) begin
      corr_valid = 1'b1; corr_val = 32'sd9999; tick();
      frame_start = 1'b1; corr_valid = 1'b0; tick();
      frame_start = 1'b0;
    end
    for (int p = 0; p < 6; p++) begin
      for (int l = -m; l <= m; l++) begin
        if (gaps && !(fs == 1 && p == 0 && l == -m)) begin
          while ($urandom_range(1, 0) == 1) begin
            corr_valid = 1'b0; corr_val = 32'sd5000; tick();
          end
        end
        if (p == 5 && l == m) begin
          for (int k = 0; k < 6; k++) pre_ld[k] = ld[k];
          pre_busy = busy;
          pre_ena2 = ena2;
        end
        frame_start = (fs == 1 && p == 0 && l == -m);
        corr_valid = 1'b1;
        corr_val = val(m, mode, p, l, pk[p]);
        tick();
        if (fs == 1 && p == 0 && l == -m) err_seen = ferr;
        frame_start = 1'b0;
      end
    end
    corr_valid = 1'b0;
  endtask

  task automatic ena_shape(output logic [5:0] got);
    for (int k = 0; k < 6; k++) begin
      got[k] = ena;
      tick();
    end
  endtask

  initial begin
    logic [5:0] got;
    int cnt;
    int pka [6];
    int pkb [6];
    vecs[0].mode = 0; vecs[0].gaps = 1'b0;
    vecs[0].pk = '{-6, -3, 0, 2, 5, 6};   vecs[0].ex = '{-6, -3, 0, 2, 5, 6};
    vecs[1].mode = 0; vecs[1].gaps = 1'b1;
    vecs[1].pk = '{-6, -3, 0, 2, 5, 6};   vecs[1].ex = '{-6, -3, 0, 2, 5, 6};
    vecs[2].mode = 1; vecs[2].gaps = 1'b0;
    vecs[2].pk = '{6, 5, -1, -4, 1, -6};  vecs[2].ex = '{6, 5, -1, -4, 1, -6};
    vecs[3].mode = 2; vecs[3].gaps = 1'b0;
    vecs[3].pk = '{0, 0, 0, 0, 0, 0};     vecs[3].ex = '{-2, -6, -6, -6, -6, -6};
    pka = '{-1, 0, 1, 1, 0, -1};
    pkb = '{1, 1, 0, -1, -1, 0};
    for (int k = 0; k < 6; k++) prev[k] = 0;
    err_seen = 1'b0;

    rst_n = 1'b0; frame_start = 1'b0; corr_valid = 1'b0; corr_val = '0;
    #3;
    for (int k = 0; k < 6; k++) chk($sformatf("reset_lag%0d", k + 1), ld[k], 0);
    chk("reset_ena", ena, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", ferr, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      send_frame(6, vecs[i].mode, vecs[i].pk, vecs[i].gaps, 0);
      chk($sformatf("v%0d_busy_in_scan", i), pre_busy, 1);
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("v%0d_hold_lag%0d", i, k + 1), pre_ld[k], prev[k]);
        chk($sformatf("v%0d_lag%0d", i, k + 1), ld[k], vecs[i].ex[k]);
      end
      chk($sformatf("v%0d_busy_done", i), busy, 0);
      ena_shape(got);
      chk($sformatf("v%0d_ena_shape", i), got, 6'b001111);
      for (int k = 0; k < 6; k++) prev[k] = vecs[i].ex[k];
    end

    // Abort at sample 40; the restart carries its own first sample.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      corr_valid = 1'b1; corr_val = 32'(n * 7); tick();
    end
    send_frame(6, 0, vecs[0].pk, 1'b0, 1);
    chk("abort_frame_err", err_seen, 1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort_hold_lag%0d", k + 1), pre_ld[k], vecs[3].ex[k]);
      chk($sformatf("abort_lag%0d", k + 1), ld[k], vecs[0].ex[k]);
    end
    chk("abort_frame_err_clear", ferr, 0);
    ena_shape(got);
    chk("abort_ena_shape", got, 6'b001111);

    // Asynchronous reset in the middle of a scan.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      corr_valid = 1'b1; corr_val = 32'(n); tick();
    end
    corr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) chk($sformatf("midrst_lag%0d", k + 1), ld[k], 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ena", ena, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(6, 1, vecs[2].pk, 1'b1, 0);
    for (int k = 0; k < 6; k++) chk($sformatf("postrst_lag%0d", k + 1), ld[k], vecs[2].ex[k]);
    ena_shape(got);
    chk("postrst_ena_shape", got, 6'b001111);

    // Back-to-back frames on the long-pulse instance.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    send_frame(1, 0, pka, 1'b0, 0);
    chk("b2b_ena_first", ena2, 1);
    for (int k = 0; k < 6; k++) chk($sformatf("b2b_a_lag%0d", k + 1), ld2[k], pka[k]);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    send_frame(1, 0, pkb, 1'b0, 2);
    chk("b2b_ena_before_trunc", pre_ena2, 1);
    chk("b2b_ena_gap", ena2, 0);
    for (int k = 0; k < 6; k++) chk($sformatf("b2b_b_lag%0d", k + 1), ld2[k], pkb[k]);
    tick();
    chk("b2b_ena_restart", ena2, 1);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (ena2) cnt++;
      tick();
    end
    chk("b2b_ena_len", cnt, 24);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
